dsp48a1_mac_sequencer: RTL and testbench

- Controller that drives one DSP48A1 slice as a signed multiply-accumulate engine.
- Accepts a job (START, LEN) and a valid/ready stream of LEN (A,B) sample pairs, then computes sum of A*B.
- Generates the slice's A/B operands, OPMODE, clock enables and reset, tracks pipeline latency, and returns the 48-bit P result on a valid/ready result port.
- Sits between the sample source and the DSP48A1 instance.

---
 rtl/dsp48a1_mac_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_dsp48a1_mac_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp48a1_mac_sequencer.sv
`timescale 1ns/1ps
// dsp48a1_mac_sequencer
// Drives a single DSP48A1 slice as a signed multiply-accumulate engine:
// takes a job (START, LEN), streams LEN operand pairs into the slice,
// waits out the slice and opcode pipelines, then returns the 48-bit P.
module dsp48a1_mac_sequencer #(
    parameter int unsigned LEN_W    = 10,
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned OPM_DLY  = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    output logic             BUSY,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [17:0]      IN_A,
    input  logic [17:0]      IN_B,
    output logic [17:0]      DSP_A,
    output logic [17:0]      DSP_B,
    output logic [7:0]       DSP_OPMODE,
    output logic             DSP_CE,
    output logic             DSP_RST,
    input  logic [47:0]      DSP_P,
    input  logic             DSP_CARRYOUT,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [47:0]      RES_DATA,
    output logic             RES_CARRY
);

    localparam int unsigned OPD_W   = 18;
    localparam int unsigned P_W     = 48;
    localparam int unsigned OPM_W   = 8;
    // Cycles from the last operand pair until P is guaranteed settled.
    localparam int unsigned DRAIN_N = PIPE_LAT + OPM_DLY;
    localparam int unsigned DCNT_W  = $clog2(DRAIN_N + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // X/Z multiplexer codes for the post-adder.
    localparam logic [OPM_W-1:0] OPM_ZERO  = 8'b0000_0000;
    localparam logic [OPM_W-1:0] OPM_FIRST = 8'b0000_0001;
    localparam logic [OPM_W-1:0] OPM_ACC   = 8'b0000_1001;
    localparam logic [OPM_W-1:0] OPM_HOLD  = 8'b0000_1000;

    logic [1:0]             state;
    logic [1:0]             state_n;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       count;
    logic [DCNT_W-1:0]      dcnt;
    logic [OPM_DLY:0][OPM_W-1:0] opm_pipe;

    logic                   start_run_c;
    logic                   start_zero_c;
    logic                   accept_c;
    logic                   last_c;
    logic                   in_job_c;
    logic                   drain_done_c;
    logic                   handshake_c;
    logic [OPM_W-1:0]       opm_c;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and per-cycle decode, including the opcode for this cycle's operands.
    always_comb begin
        state_n      = state;
        start_run_c  = 1'b0;
        start_zero_c = 1'b0;
        accept_c     = 1'b0;
        last_c       = 1'b0;
        in_job_c     = 1'b0;
        drain_done_c = 1'b0;
        handshake_c  = 1'b0;
        opm_c        = OPM_HOLD;
        case (state)
            S_IDLE: begin
                opm_c = OPM_ZERO;
                if (START) begin
                    if (LEN == '0) begin
                        start_zero_c = 1'b1;
                        state_n      = S_DONE;
                    end else begin
                        start_run_c = 1'b1;
                        state_n     = S_RUN;
                    end
                end
            end
            S_RUN: begin
                in_job_c = 1'b1;
                accept_c = IN_VALID && IN_READY;
                last_c   = accept_c && (count == len_q - LEN_W'(1));
                if (accept_c) begin
                    opm_c = (count == '0) ? OPM_FIRST : OPM_ACC;
                end else begin
                    opm_c = (count == '0) ? OPM_ZERO : OPM_HOLD;
                end
                if (last_c) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                in_job_c     = 1'b1;
                drain_done_c = (dcnt == '0);
                if (drain_done_c) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                handshake_c = RES_READY;
                if (handshake_c) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Job control: busy flag, input ready, slice enable/reset, counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BUSY     <= 1'b0;
            IN_READY <= 1'b0;
            DSP_CE   <= 1'b0;
            DSP_RST  <= 1'b1;
            len_q    <= '0;
            count    <= '0;
            dcnt     <= '0;
        end else begin
            DSP_RST <= 1'b0;
            if (start_run_c) begin
                BUSY     <= 1'b1;
                IN_READY <= 1'b1;
                DSP_CE   <= 1'b1;
                len_q    <= LEN;
                count    <= '0;
            end
            if (start_zero_c) begin
                BUSY <= 1'b1;
            end
            if (accept_c) begin
                count <= count + LEN_W'(1);
            end
            if (last_c) begin
                IN_READY <= 1'b0;
                dcnt     <= DCNT_W'(DRAIN_N);
            end else if ((state == S_DRAIN) && (dcnt != '0)) begin
                dcnt <= dcnt - DCNT_W'(1);
            end
            if (handshake_c) begin
                BUSY   <= 1'b0;
                DSP_CE <= 1'b0;
            end
        end
    end

    // Operand issue; the opcode trails its operands by OPM_DLY cycles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DSP_A    <= '0;
            DSP_B    <= '0;
            opm_pipe <= '0;
        end else begin
            DSP_A       <= accept_c ? IN_A : OPD_W'(0);
            DSP_B       <= accept_c ? IN_B : OPD_W'(0);
            opm_pipe[0] <= opm_c;
            for (int unsigned i = 1; i <= OPM_DLY; i++) begin
                opm_pipe[i] <= opm_pipe[i-1];
            end
        end
    end

    assign DSP_OPMODE = opm_pipe[OPM_DLY];

    // Result capture, sticky carry and result handshake.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RES_VALID <= 1'b0;
            RES_DATA  <= '0;
            RES_CARRY <= 1'b0;
        end else begin
            if (start_run_c || start_zero_c) begin
                RES_CARRY <= 1'b0;
            end else if (in_job_c) begin
                RES_CARRY <= RES_CARRY | DSP_CARRYOUT;
            end
            if (start_zero_c) begin
                RES_DATA  <= P_W'(0);
                RES_VALID <= 1'b1;
            end
            if (drain_done_c) begin
                RES_DATA  <= DSP_P;
                RES_VALID <= 1'b1;
            end
            if (handshake_c) begin
                RES_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
`timescale 1ns/1ps
// Bench for dsp48a1_mac_sequencer: a behavioural DSP48A1 slice closes the
// loop, jobs are scored against plain sum-of-products arithmetic.
module tb_dsp48a1_mac_sequencer;

    localparam int unsigned LEN_W    = 10;
    localparam int unsigned PIPE_LAT = 4;
    localparam int unsigned OPM_DLY  = 2;
    localparam int LAT    = int'(PIPE_LAT + OPM_DLY) + 1;
    localparam int MAXLEN = 16;

    typedef struct { logic [47:0] data; logic carry; } exp_t;
    typedef struct { int lo; int hi; } win_t;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             START = 1'b0;
    logic [LEN_W-1:0] LEN = '0;
    logic             BUSY;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [17:0]      IN_A = '0;
    logic [17:0]      IN_B = '0;
    logic [17:0]      DSP_A;
    logic [17:0]      DSP_B;
    logic [7:0]       DSP_OPMODE;
    logic             DSP_CE;
    logic             DSP_RST;
    logic [47:0]      DSP_P;
    logic             carry_inj = 1'b0;
    logic             RES_VALID;
    logic             RES_READY = 1'b0;
    logic [47:0]      RES_DATA;
    logic             RES_CARRY;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by stimulus

    logic signed [17:0] ja [MAXLEN];
    logic signed [17:0] jb [MAXLEN];
    int                 jgap [MAXLEN];
    exp_t exp_q[$];
    win_t rise_q[$];

    dsp48a1_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT), .OPM_DLY(OPM_DLY)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .LEN(LEN), .BUSY(BUSY),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
        .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE), .DSP_CE(DSP_CE),
        .DSP_RST(DSP_RST), .DSP_P(DSP_P), .DSP_CARRYOUT(carry_inj),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
        .RES_CARRY(RES_CARRY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Slice model: A0/B0, A1/B1, M, P registers plus registered OPMODE.
    logic signed [17:0] s_a0 = '0, s_a1 = '0, s_b0 = '0, s_b1 = '0;
    logic signed [35:0] s_m = '0;
    logic [7:0]         s_opm = '0;
    logic [47:0]        s_p = '0;
    logic [47:0]        s_mx;
    assign s_mx  = {{12{s_m[35]}}, s_m};
    assign DSP_P = s_p;
    always @(posedge CLK) begin
        if (DSP_RST) begin
            s_a0 <= '0; s_a1 <= '0; s_b0 <= '0; s_b1 <= '0;
            s_m <= '0; s_opm <= '0; s_p <= '0;
        end else if (DSP_CE) begin
            s_a0  <= DSP_A;
            s_b0  <= DSP_B;
            s_a1  <= s_a0;
            s_b1  <= s_b0;
            s_m   <= s_a1 * s_b1;
            s_opm <= DSP_OPMODE;
            s_p   <= ((s_opm[3:2] == 2'b10) ? s_p : 48'd0) + ((s_opm[1:0] == 2'b01) ? s_mx : 48'd0);
        end
    end

    // Result consumer ready generator.
    always @(negedge CLK) begin
        if (ready_mode == 0) RES_READY = 1'b1;
        else if (ready_mode == 1) RES_READY = 1'($urandom_range(1, 0));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic abort(input string name);
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ctrl"}, 64'({BUSY, IN_READY, DSP_CE, RES_VALID, RES_CARRY, DSP_RST}), 64'(6'b000001));
        chk({name, "_dsp"}, 64'({DSP_A, DSP_B, DSP_OPMODE}), 64'(0));
        chk({name, "_data"}, 64'(RES_DATA), 64'(0));
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((BUSY || RES_VALID) && t < 400) begin
            @(negedge CLK);
            t++;
        end
        if (BUSY || RES_VALID) abort("wait_idle");
    endtask

    // Issue one job from ja/jb/jgap; expected result comes from plain arithmetic.
    task automatic run_job(input int len, input bit inj, input bit wait_done);
        logic [47:0] sum;
        exp_t e;
        win_t w;
        int start_edge, acc_edge, t;
        logic bad;
        sum = '0;
        for (int i = 0; i < len; i++) begin
            longint p;
            p = longint'(ja[i]) * longint'(jb[i]);
            sum = sum + p[47:0];
        end
        e.data = sum;
        e.carry = inj;
        exp_q.push_back(e);
        START = 1'b1;
        LEN = LEN_W'(len);
        @(negedge CLK);
        START = 1'b0;
        start_edge = cyc;
        acc_edge = cyc;
        if (len == 0) begin
            w.lo = start_edge;
            w.hi = start_edge + 2;
            rise_q.push_back(w);
        end else begin
            for (int i = 0; i < len; i++) begin
                IN_VALID = 1'b0;
                repeat (jgap[i]) @(negedge CLK);
                IN_VALID = 1'b1;
                IN_A = ja[i];
                IN_B = jb[i];
                if (inj && i == 0) carry_inj = 1'b1;
                t = 0;
                while (!IN_READY && t < 50) begin
                    @(negedge CLK);
                    t++;
                end
                if (!IN_READY) abort("in_ready_wait");
                @(negedge CLK);
                acc_edge = cyc;
                carry_inj = 1'b0;
            end
            IN_VALID = 1'b0;
            chk("in_ready_after_last", 64'(IN_READY), 64'(0));
            w.lo = acc_edge + LAT;
            w.hi = acc_edge + LAT;
            rise_q.push_back(w);
        end
        if (wait_done) begin
            bad = 1'b0;
            t = 0;
            while (BUSY && t < 300) begin
                if (len == 0) bad = bad | DSP_CE | IN_READY;
                @(negedge CLK);
                t++;
            end
            if (BUSY) abort("job_done_wait");
            if (len == 0) chk("zero_len_ce_ready", 64'(bad), 64'(0));
        end
    endtask

    // Monitor: compares every presented result against the scoreboard.
    initial begin : monitor
        exp_t e;
        win_t w;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge CLK);
            #1;
            if (!RST_N) begin
                prev_valid = 1'b0;
            end else begin
                if (RES_VALID && !prev_valid) begin
                    checks++;
                    if (rise_q.size() == 0) begin
                        failures++;
                        $display("FAIL res_rise actual=rise@%0d required=no_result", cyc);
                    end else begin
                        w = rise_q.pop_front();
                        if (cyc < w.lo || cyc > w.hi) begin
                            failures++;
                            $display("FAIL res_latency actual=%0d required=%0d..%0d", cyc, w.lo, w.hi);
                        end
                    end
                end
                if (RES_VALID) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL res_unexpected actual=%0h required=none", RES_DATA);
                    end else begin
                        e = exp_q[0];
                        chk("res_data", 64'(RES_DATA), 64'(e.data));
                        chk("res_carry", 64'(RES_CARRY), 64'(e.carry));
                        if (RES_READY) e = exp_q.pop_front();
                    end
                end
                prev_valid = RES_VALID;
            end
        end
    end

    initial begin : watchdog
        #500000;
        abort("global_watchdog");
    end

    initial begin : stimulus
        int t;
        // Reset values
        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        RST_N = 1'b1;
        @(negedge CLK);
        chk("dsp_rst_release", 64'(DSP_RST), 64'(0));

        // Back-to-back three-pair job: 3*6 + 5*7 + 9*5 = 0x62
        ja[0] = 18'sd3; jb[0] = 18'sd6; jgap[0] = 0;
        ja[1] = 18'sd5; jb[1] = 18'sd7; jgap[1] = 0;
        ja[2] = 18'sd9; jb[2] = 18'sd5; jgap[2] = 0;
        wait_idle();
        run_job(3, 1'b0, 1'b1);

        // Same job with a three-cycle bubble before pair 2
        jgap[1] = 3;
        wait_idle();
        run_job(3, 1'b0, 1'b1);

        // Negative product: -2 * 3
        ja[0] = -18'sd2; jb[0] = 18'sd3; jgap[0] = 0;
        wait_idle();
        run_job(1, 1'b0, 1'b1);

        // Zero-length job
        wait_idle();
        run_job(0, 1'b0, 1'b1);

        // Result held while consumer stalls; START during DONE ignored
        ready_mode = 2;
        RES_READY = 1'b0;
        ja[0] = 18'sd7; jb[0] = 18'sd9; jgap[0] = 0;
        wait_idle();
        run_job(1, 1'b1, 1'b0);
        t = 0;
        while (!RES_VALID && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (!RES_VALID) abort("hold_valid_wait");
        repeat (2) @(negedge CLK);
        START = 1'b1;
        LEN = LEN_W'(3);
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        chk("hold_busy", 64'(BUSY), 64'(1));
        chk("hold_valid", 64'(RES_VALID), 64'(1));
        chk("hold_in_ready", 64'(IN_READY), 64'(0));
        RES_READY = 1'b1;
        START = 1'b1;
        LEN = LEN_W'(2);
        @(negedge CLK);
        START = 1'b0;
        RES_READY = 1'b0;
        chk("handshake_busy", 64'(BUSY), 64'(0));
        chk("handshake_start_ignored", 64'(IN_READY), 64'(0));
        @(negedge CLK);
        chk("idle_after_handshake", 64'(BUSY), 64'(0));
        ready_mode = 0;
        ja[0] = 18'sd1; jb[0] = 18'sd1; jgap[0] = 0;
        ja[1] = 18'sd2; jb[1] = 18'sd2; jgap[1] = 0;
        wait_idle();
        run_job(2, 1'b0, 1'b1);

        // Reset in the middle of a job abandons it
        wait_idle();
        START = 1'b1;
        LEN = LEN_W'(6);
        @(negedge CLK);
        START = 1'b0;
        IN_VALID = 1'b1;
        IN_A = 18'sd11;
        IN_B = 18'sd13;
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("midrun_dsp_rst", 64'(DSP_RST), 64'(1));
        RST_N = 1'b1;
        @(negedge CLK);
        chk("midrun_dsp_rst_release", 64'(DSP_RST), 64'(0));
        chk("midrun_busy", 64'(BUSY), 64'(0));
        repeat (12) @(negedge CLK);
        ja[0] = 18'sd3; jb[0] = 18'sd6; jgap[0] = 0;
        ja[1] = 18'sd5; jb[1] = 18'sd7; jgap[1] = 0;
        ja[2] = 18'sd9; jb[2] = 18'sd5; jgap[2] = 0;
        run_job(3, 1'b0, 1'b1);

        // Randomized jobs: random operands, bubbles, carry pulses and consumer stalls
        for (int j = 0; j < 24; j++) begin
            int len;
            bit inj;
            len = int'($urandom_range(8, 0));
            inj = ($urandom_range(2, 0) == 0) && (len > 0);
            for (int i = 0; i < len; i++) begin
                ja[i] = 18'($urandom);
                jb[i] = 18'($urandom);
                jgap[i] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            end
            if (j == 0) begin
                ja[0] = -18'sd131072;
                jb[0] = -18'sd131072;
            end
            ready_mode = j % 2;
            wait_idle();
            run_job(len, inj, 1'b1);
        end

        ready_mode = 0;
        wait_idle();
        repeat (10) @(negedge CLK);
        chk("results_outstanding", 64'(exp_q.size()), 64'(0));
        chk("rises_outstanding", 64'(rise_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
